serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial, multi-cycle subtractor computing a − b one bit per clock, LSB first, with a start/done handshake. It complements the combinational ripple adder: the same operand widths and adder test vectors apply in the subtract direction. It trades latency for one full-subtractor cell plus shift registers. It serves as the arithmetic unit for datapaths that can tolerate WIDTH-cycle latency.

## Interface
- WIDTH, default 4: operand, difference and counter width basis; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend; captured on the accepting edge only.
- b  input  WIDTH  subtrahend; captured on the accepting edge only.
- busy  output  1  high while in SHIFT.
- done  output  1  single-cycle pulse when the result becomes valid.
- diff  output  WIDTH  (a − b) mod 2^WIDTH; registered and held until the next result.
- borrow  output  1  1 when a < b (unsigned); registered and held with diff.

## Operation
- States:
  - IDLE: reset state.
  - SHIFT: runs WIDTH bit-steps.
  - DONE: lasts one cycle.
- Transitions:
  - IDLE→SHIFT on start.
  - SHIFT→DONE after the WIDTH-th bit-step.
  - DONE→SHIFT if start, otherwise DONE→IDLE.
- Accept edge:
  - a_sh←a, b_sh←b.
  - d_sh←0, br←0, cnt←0.
- Each SHIFT edge:
  - d = a_sh[0] ^ b_sh[0] ^ br.
  - br ← (~a_sh[0] & b_sh[0]) | (~(a_sh[0]^b_sh[0]) & br).
  - a_sh and b_sh shift right one bit.
  - d_sh ← {d, d_sh[WIDTH-1:1]}.
  - cnt increments.
- Final SHIFT edge (cnt == WIDTH−1):
  - diff ← {d, d_sh[WIDTH-1:1]}.
  - borrow ← new br.
  - State → DONE.
- start during SHIFT is ignored; the operation in flight is neither aborted nor restarted.
- a/b changes after the accept edge have no effect.
- diff and borrow change only on the final SHIFT edge or on reset.
- Result identity: {borrow, diff} == ({1'b0,a} − {1'b0,b}) taken modulo 2^(WIDTH+1).
- cnt width: $clog2(WIDTH); it never wraps in normal use.

## Timing
- Reset (rst high at a rising edge) forces:
  - state=IDLE, busy=0, done=0, diff=0, borrow=0.
  - Internal a_sh/b_sh/d_sh/br/cnt = 0.
- rst takes priority over every other input, including mid-SHIFT; the partial result is discarded and diff/borrow read 0.
- Latency: start sampled at edge E0, busy=1 from E0 through E(WIDTH−1). At E(WIDTH), diff/borrow update, done=1, busy=0. done therefore rises WIDTH cycles after the accept edge (4 cycles for WIDTH=4).
- done is high for exactly one cycle, the DONE cycle.
- Back-to-back: start high during the DONE cycle is accepted at that edge. Throughput is one result per WIDTH+1 cycles.
- busy and done are never high together.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package serial_subtractor_pkg:
  - state typedef enum {IDLE, SHIFT, DONE}.
  - localparam DEFAULT_WIDTH = 4.
- Sub-module full_subtractor (combinational; ports a, b, bin, d, bout) holds the 1-bit difference/borrow equations; the top instantiates it once.
- Top: state register, counter, three shift registers, borrow flip-flop, output registers.

## Test plan
- Reset then idle, start=0: busy=0, done=0, diff=0, borrow=0 for 10 cycles.
- a=4'h7, b=4'h3, 1-cycle start → done exactly 4 cycles after the accept edge, diff=4'h4, borrow=0; values held 20 cycles.
- Adder-vector set run back-to-back, start held high through DONE: (2,3)→F/1, (4,7)→D/1, (5,A)→B/1, (6,E)→8/1, (D,9)→4/0, (0,0)→0/0. Check accept spacing is 5 cycles and each done pulse is 1 cycle wide.
- Boundaries: (F,F)→0/0; (0,1)→F/1; (F,0)→F/0; (8,7)→1/0.
- start pulsed and a/b changed at cycle 2 of SHIFT with a=9, b=2: ignored, result 7/0, exactly one done pulse.
- rst asserted during the 2nd SHIFT cycle of (5,A): next cycle busy=0, done=0, diff=0, borrow=0. No done pulse follows; a new start of (5,A) → B/1.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_pkg
// Desc     : Shared state encoding and default width for serial_subtractor.
// Revision : 1.0
// ============================================================================
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : full_subtractor
// Desc     : One-bit difference/borrow cell, evaluated once per bit-step.
// Revision : 1.0
// ============================================================================
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Desc     : Bit-serial a - b, LSB first, one bit per clock, start/done handshake.
// Revision : 1.0
// ============================================================================
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  // Bit 0 of the conceptual difference shifter would be shifted out unread,
  // so only the upper WIDTH-1 bits are stored.
  logic [WIDTH-2:0] d_sh_q;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic             bit_d;
  logic             br_d;
  logic [WIDTH-1:0] diff_d;

  full_subtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (br_d)
  );

  assign diff_d = {bit_d, d_sh_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      d_sh_q   <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            a_sh_q  <= a;
            b_sh_q  <= b;
            d_sh_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        SHIFT: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          d_sh_q <= diff_d[WIDTH-1:1];
          br_q   <= br_d;
          if (cnt_q == CNT_LAST) begin
            // Counter is re-zeroed on the next accept, so it is not stepped here.
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            diff_q   <= diff_d;
            borrow_q <= br_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Desc     : Scoreboard bench for serial_subtractor against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    int           acc_cycle;
  } exp_t;

  exp_t sb[$];
  int   checks     = 0;
  int   failures   = 0;
  int   cycle      = 0;
  int   done_count = 0;
  bit   mon_en     = 1'b0;
  logic done_prev  = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: unsigned subtraction widened by one bit gives {borrow, diff}.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input int acc);
    logic [W:0] r;
    exp_t e;
    r = {1'b0, ma} - {1'b0, mb};
    e.diff      = r[W-1:0];
    e.borrow    = r[W];
    e.acc_cycle = acc;
    return e;
  endfunction

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
      if (done === 1'b1) begin
        done_count++;
        check("done_one_cycle", {31'd0, done_prev}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("diff", {28'd0, diff}, {28'd0, e.diff});
          check("borrow", {31'd0, borrow}, {31'd0, e.borrow});
          check("latency", cycle - e.acc_cycle, W);
        end
      end
      done_prev = done;
    end
  end

  // Drives one request for a single cycle; DUT must be idle or in DONE.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(model(ia, ib, cycle));
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", {31'd0, (n >= 100)}, 32'd0);
    if (n >= 100) sb.delete();
  endtask

  logic [W-1:0] va[6] = '{4'h2, 4'h4, 4'h5, 4'h6, 4'hD, 4'h0};
  logic [W-1:0] vb[6] = '{4'h3, 4'h7, 4'hA, 4'hE, 4'h9, 4'h0};
  logic [W-1:0] ba[4] = '{4'hF, 4'h0, 4'hF, 4'h8};
  logic [W-1:0] bb[4] = '{4'hF, 4'h1, 4'h0, 4'h7};

  initial begin
    int last_acc;
    int dc0;
    int n;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_diff", {28'd0, diff}, 32'd0);
      check("rst_borrow", {31'd0, borrow}, 32'd0);
    end

    // Single operation, then hold
    issue(4'h7, 4'h3);
    drain();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_diff", {28'd0, diff}, 32'h4);
      check("hold_borrow", {31'd0, borrow}, 32'd0);
    end

    // Back-to-back with start held high through DONE
    start    = 1'b1;
    last_acc = 0;
    for (int i = 0; i < 6; i++) begin
      a = va[i];
      b = vb[i];
      if (i > 0) begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (done !== 1'b1 && n < 3 * W);
        check("b2b_done_timeout", {31'd0, (done !== 1'b1)}, 32'd0);
      end
      @(posedge clk);
      #1;
      sb.push_back(model(va[i], vb[i], cycle));
      if (i > 0) check("b2b_spacing", cycle - last_acc, W + 1);
      last_acc = cycle;
    end
    start = 1'b0;
    drain();

    // Boundaries
    for (int i = 0; i < 4; i++) begin
      issue(ba[i], bb[i]);
      drain();
    end

    // Randomized operands with random idle gaps
    for (int i = 0; i < 30; i++) begin
      issue(W'($urandom), W'($urandom));
      drain();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // start and operand changes during SHIFT are ignored
    dc0 = done_count;
    issue(4'h9, 4'h2);
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 4'hF;
    b     = 4'hF;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    repeat (2 * W) @(negedge clk);
    check("ignored_start_done_count", done_count - dc0, 1);

    // Reset in the second SHIFT cycle discards the operation
    dc0   = done_count;
    a     = 4'h5;
    b     = 4'hA;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_diff", {28'd0, diff}, 32'd0);
    check("midrst_borrow", {31'd0, borrow}, 32'd0);
    repeat (3 * W) @(negedge clk);
    check("midrst_no_done", done_count - dc0, 0);
    issue(4'h5, 4'hA);
    drain();
    check("post_rst_done_count", done_count - dc0, 1);

    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=<200000", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
